// File: rtl/program_loader.sv
// Host-side instruction-memory loader: frames a byte stream into big-endian words and writes imem from address 0.
// Latency: a word is written on the cycle after its last byte transfers; cpu_rst falls the cycle after the final write.
// Backpressure: in_ready is high only while a frame is in progress; it is low in DONE and ERROR until load_req restarts.
// Optional feature: define LOADER_CHECKSUM_EN to expect a trailing XOR checksum byte (CHK state).
module program_loader #(
    parameter int instructionSize = 24,
    parameter int addrWidth       = 16,
    parameter int depth           = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [7:0]                 in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       load_req,
    output logic                       imem_we,
    output logic [addrWidth-1:0]       imem_addr,
    output logic [instructionSize-1:0] imem_wdata,
    output logic                       cpu_rst,
    output logic                       loaded,
    output logic                       err
);

    localparam int          BYTES   = instructionSize / 8;
    localparam int          BCW     = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [16:0] DEPTH_L = 17'(depth);

    typedef enum logic [2:0] {
        LEN_HI = 3'd0,
        LEN_LO = 3'd1,
        DATA   = 3'd2,
        CHK    = 3'd3,
        DONE   = 3'd4,
        ERROR  = 3'd5
    } state_t;

    state_t                     state_q, state_d;
    logic [15:0]                len_q, len_d;
    logic [BCW-1:0]             bcnt_q, bcnt_d;
    logic [15:0]                wcnt_q, wcnt_d;
    logic [instructionSize-1:0] asm_q, asm_d;
    logic [7:0]                 chk_q, chk_d;
    logic                       we_q, we_d;
    logic [addrWidth-1:0]       addr_q, addr_d;
    logic [instructionSize-1:0] wdata_q, wdata_d;
    logic                       cpu_rst_q, cpu_rst_d;
    logic                       loaded_q, loaded_d;
    logic                       err_q, err_d;

    logic                       xfer;
    logic [15:0]                n_full;
    logic [15:0]                wcnt_nxt;
    logic [instructionSize-1:0] asm_shift;

    assign in_ready   = (state_q == LEN_HI) || (state_q == LEN_LO) ||
                        (state_q == DATA)   || (state_q == CHK);
    assign xfer       = in_valid && in_ready;
    assign n_full     = {len_q[15:8], in_data};
    assign wcnt_nxt   = wcnt_q + 16'd1;
    assign asm_shift  = (asm_q << 8) | instructionSize'(in_data);

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign cpu_rst    = cpu_rst_q;
    assign loaded     = loaded_q;
    assign err        = err_q;

    // Frame parser: header capture, word assembly, write strobe generation and restart handling.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        bcnt_d  = bcnt_q;
        wcnt_d  = wcnt_q;
        asm_d   = asm_q;
        chk_d   = chk_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;

        case (state_q)
            LEN_HI: begin
                if (xfer) begin
                    len_d[15:8] = in_data;
                    chk_d       = chk_q ^ in_data;
                    state_d     = LEN_LO;
                end
            end
            LEN_LO: begin
                if (xfer) begin
                    len_d[7:0] = in_data;
                    chk_d      = chk_q ^ in_data;
                    if ({1'b0, n_full} > DEPTH_L) begin
                        state_d = ERROR;
                    end else if (n_full == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
                        state_d = CHK;
`else
                        state_d = DONE;
`endif
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (xfer) begin
                    chk_d = chk_q ^ in_data;
                    asm_d = asm_shift;
                    if (bcnt_q == BCW'(BYTES - 1)) begin
                        // Final byte of a word: emit exactly one write for it.
                        bcnt_d  = '0;
                        we_d    = 1'b1;
                        wdata_d = asm_shift;
                        addr_d  = addrWidth'(wcnt_q);
                        wcnt_d  = wcnt_nxt;
                        if (wcnt_nxt == len_q) begin
`ifdef LOADER_CHECKSUM_EN
                            state_d = CHK;
`else
                            state_d = DONE;
`endif
                        end
                    end else begin
                        bcnt_d = bcnt_q + BCW'(1);
                    end
                end
            end
            CHK: begin
`ifdef LOADER_CHECKSUM_EN
                if (xfer) begin
                    state_d = (in_data == chk_q) ? DONE : ERROR;
                end
`else
                // Not reachable without the checksum trailer; treat as a protocol fault.
                state_d = ERROR;
`endif
            end
            DONE, ERROR: begin
                if (load_req) begin
                    state_d = LEN_HI;
                    len_d   = '0;
                    bcnt_d  = '0;
                    wcnt_d  = '0;
                    asm_d   = '0;
                    chk_d   = '0;
                end
            end
            default: state_d = ERROR;
        endcase
    end

    // Status outputs: cpu_rst drops only after a full cycle spent in DONE, and rises at once on restart.
    always_comb begin
        cpu_rst_d = (state_d != DONE) || (state_q != DONE);
        loaded_d  = (state_d == DONE);
        err_d     = (state_d == ERROR);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= LEN_HI;
            len_q     <= '0;
            bcnt_q    <= '0;
            wcnt_q    <= '0;
            asm_q     <= '0;
            chk_q     <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            cpu_rst_q <= 1'b1;
            loaded_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            bcnt_q    <= bcnt_d;
            wcnt_q    <= wcnt_d;
            asm_q     <= asm_d;
            chk_q     <= chk_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            cpu_rst_q <= cpu_rst_d;
            loaded_q  <= loaded_d;
            err_q     <= err_d;
        end
    end

endmodule
